// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sequences one read or write per request against an asynchronous
// EN/RW/MFC memory, with a 2-flop MFC synchroniser and a per-phase timeout.
module mem_bus_ctrl #(
   parameter int DW        = 16,
   parameter int AW        = 16,
   parameter int TIMEOUT   = 64,
   parameter int SETUP_CYC = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic [DW-1:0] o_rdata,
   output logic [AW-1:0] o_mar_to_mem,
   output logic [DW-1:0] o_mdr_to_mem,
   input  logic [DW-1:0] i_mem_to_mdr,
   output logic          o_rw,
   output logic          o_en,
   input  logic          i_mfc
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(SETUP_CYC + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_mar, w_mar_nxt;
   logic [DW-1:0] r_mdr, w_mdr_nxt;
   logic          r_rw, w_rw_nxt;
   logic          r_en, w_en_nxt;
   logic          r_err, w_err_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [SW-1:0] r_scnt, w_scnt_nxt;
   logic          r_mfc_meta, r_mfc_s;
   logic          w_cnt_last, w_setup_last;

   assign w_cnt_last   = r_cnt == CW'(TIMEOUT - 1);
   assign w_setup_last = r_scnt == SW'(SETUP_CYC - 1);

   assign o_busy       = r_state != S_IDLE;
   assign o_done       = r_state == S_DONE;
   assign o_err        = r_err;
   assign o_rdata      = r_mdr;
   assign o_mar_to_mem = r_mar;
   assign o_mdr_to_mem = r_mdr;
   assign o_rw         = r_rw;
   assign o_en         = r_en;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_mar      <= '0;
         r_mdr      <= '0;
         r_rw       <= 1'b1;
         r_en       <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
         r_scnt     <= '0;
         r_mfc_meta <= 1'b0;
         r_mfc_s    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mar      <= w_mar_nxt;
         r_mdr      <= w_mdr_nxt;
         r_rw       <= w_rw_nxt;
         r_en       <= w_en_nxt;
         r_err      <= w_err_nxt;
         r_cnt      <= w_cnt_nxt;
         r_scnt     <= w_scnt_nxt;
         r_mfc_meta <= i_mfc;
         r_mfc_s    <= r_mfc_meta;
      end
   end

   // en is only ever set/cleared on state transitions so it stays a clean register output
   always_comb begin
      w_state_nxt = r_state;
      w_mar_nxt   = r_mar;
      w_mdr_nxt   = r_mdr;
      w_rw_nxt    = r_rw;
      w_en_nxt    = r_en;
      w_err_nxt   = r_err;
      w_cnt_nxt   = r_cnt;
      w_scnt_nxt  = r_scnt;
      case (r_state)
         S_IDLE:
            if (i_req) begin
               w_mar_nxt   = i_addr;
               w_rw_nxt    = ~i_we;
               w_mdr_nxt   = i_we ? i_wdata : r_mdr;
               w_err_nxt   = 1'b0;
               w_scnt_nxt  = '0;
               w_state_nxt = S_SETUP;
            end
         S_SETUP: begin
            w_scnt_nxt = r_scnt + SW'(1);
            if (w_setup_last) begin
               w_en_nxt    = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_STROBE;
            end
         end
         S_STROBE: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_mfc_s) begin
               w_mdr_nxt   = r_rw ? i_mem_to_mdr : r_mdr;
               w_en_nxt    = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_RELEASE;
            end else if (w_cnt_last) begin
               w_en_nxt    = 1'b0;
               w_err_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (!r_mfc_s) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_DONE;
            end else if (w_cnt_last) begin
               w_err_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:
            w_state_nxt = S_IDLE;
         default: begin
            w_en_nxt    = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: random and directed transfers against a memory responder, checked
// cycle by cycle against a transaction-level model of MAR/MDR/err/rdata.
module tb_mem_bus_ctrl;
   localparam int TIMEOUT   = 8;
   localparam int SETUP_CYC = 3;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic        err;
   } xfer_t;

   logic        clk = 0, rst_n = 0, req = 0, we = 0, mfc = 0;
   logic [15:0] addr = 0, wdata = 0, mem_data = 0;
   logic        busy, done, err, rw, en;
   logic [15:0] rdata, mar, mdr;

   int          n_chk = 0, n_pass = 0, n_done = 0, last_en_cyc = 0;
   logic        mon_on = 0, stuck = 0;
   logic [15:0] dev_mem [256];
   logic [15:0] ref_mem [256];
   logic [15:0] model_mdr = 0, exp_rdata = 0;
   logic        exp_err = 0;
   xfer_t       q [$];

   mem_bus_ctrl #(.DW(16), .AW(16), .TIMEOUT(TIMEOUT), .SETUP_CYC(SETUP_CYC)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
      .o_mar_to_mem(mar), .o_mdr_to_mem(mdr), .i_mem_to_mdr(mem_data), .o_rw(rw),
      .o_en(en), .i_mfc(mfc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
   endtask

   // asynchronous memory: answers a strobe after 0..2 cycles, drops mfc once en falls
   initial begin
      int dly = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) mfc = 0;
         else if (en && !mfc && !stuck) begin
            if (dly == 0) begin
               if (!rw) dev_mem[mar[7:0]] = mdr;
               mem_data = dev_mem[mar[7:0]];
               mfc = 1;
            end else dly--;
         end else if (!en && mfc) begin
            mfc = 0;
            mem_data = 16'($urandom);
         end
         if (!en && !mfc) dly = $urandom_range(0, 2);
      end
   end

   // compare process: everything checked against the transaction at the head of the model queue
   initial begin
      xfer_t cur;
      logic  have_cur = 0, prev_busy = 0, prev_done = 0, prev_en = 0;
      int    cyc = 0, en_cyc = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!mon_on || !rst_n) begin
            have_cur = 0; prev_busy = 0; prev_done = 0; prev_en = 0;
            continue;
         end
         if (busy && !prev_busy) begin
            if (q.size() == 0) chk("unexpected_accept", 1, 0);
            else begin
               cur = q.pop_front(); have_cur = 1; cyc = 0; en_cyc = 0;
               chk("err_cleared_on_accept", err, 0);
            end
         end else if (busy) cyc++;
         if (prev_done) begin
            chk("done_one_cycle", done, 0);
            chk("idle_after_done", busy, 0);
         end
         if (busy && have_cur) begin
            chk("mar", mar, cur.addr);
            chk("rw", rw, !cur.we);
            if (cur.we) chk("mdr_to_mem", mdr, cur.wdata);
            if (en) en_cyc++;
            if (en && !prev_en) chk("setup_before_en", cyc >= SETUP_CYC, 1);
            if (done) begin
               chk("err_at_done", err, cur.err);
               chk("rdata_at_done", rdata, cur.rdata);
               if (cur.err) chk("en_cycles_timeout", en_cyc, TIMEOUT);
               else chk("en_cycles_ok", en_cyc >= 2 && en_cyc < TIMEOUT, 1);
               chk("latency", cyc <= SETUP_CYC + 2 * TIMEOUT + 4, 1);
               exp_rdata = cur.rdata; exp_err = cur.err; last_en_cyc = en_cyc;
               n_done++; have_cur = 0;
            end
         end
         if (!busy) begin
            chk("idle_en", en, 0);
            chk("idle_done", done, 0);
            chk("idle_rdata", rdata, exp_rdata);
            chk("idle_err", err, exp_err);
         end
         prev_busy = busy; prev_done = done; prev_en = en;
      end
   end

   task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d, input logic stk);
      xfer_t e;
      e.we = w; e.addr = a; e.wdata = d; e.err = stk;
      e.rdata = w ? d : (stk ? model_mdr : ref_mem[a[7:0]]);
      if (w && !stk) ref_mem[a[7:0]] = d;
      model_mdr = e.rdata;
      q.push_back(e);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!busy && !done) return;
      end
      chk("wait_idle_bound", 0, 1);
   endtask

   task automatic do_xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic stk, input logic rnd_req);
      wait_idle();
      stuck = stk;
      push(w, a, d, stk);
      we = w; addr = a; wdata = d; req = 1;
      @(negedge clk);
      for (int k = 0; k < 300; k++) begin
         if (done) begin
            req = 0;
            return;
         end
         req = rnd_req ? 1'($urandom) : 1'b0;
         @(negedge clk);
      end
      req = 0;
      chk("xfer_done_bound", 0, 1);
   endtask

   initial begin
      int d0, ndone;
      logic [15:0] v;
      for (int i = 0; i < 256; i++) begin
         v = 16'($urandom); dev_mem[i] = v; ref_mem[i] = v;
      end
      dev_mem[1] = 16'hF0AF; ref_mem[1] = 16'hF0AF;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_en", en, 0);
      chk("rst_rw", rw, 1);
      chk("rst_mar", mar, 0);
      chk("rst_mdr", mdr, 0);
      chk("rst_rdata", rdata, 0);
      rst_n = 1;
      @(negedge clk);
      mon_on = 1;

      do_xfer(1, 16'h0010, 16'hBEEF, 0, 0);
      chk("wr_err", err, 0);
      chk("wr_mdr_literal", mdr, 16'hBEEF);
      do_xfer(0, 16'h0010, 16'h0000, 0, 0);
      chk("rd_0010_literal", rdata, 16'hBEEF);
      do_xfer(0, 16'h0001, 16'h0000, 0, 0);
      chk("rd_0001_literal", rdata, 16'hF0AF);

      do_xfer(0, 16'h0020, 16'h0000, 1, 0);
      chk("timeout_err_literal", err, 1);
      chk("timeout_en_literal", last_en_cyc, 8);
      do_xfer(0, 16'h0001, 16'h0000, 0, 0);
      chk("err_cleared_literal", err, 0);

      wait_idle();
      d0 = n_done; ndone = 0;
      for (int i = 0; i < 3; i++) push(0, 16'h0010, 16'h0000, 0);
      we = 0; addr = 16'h0010; req = 1;
      for (int k = 0; k < 600 && ndone < 3; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      req = 0;
      chk("b2b_done_count", n_done - d0, 3);
      chk("b2b_rdata_literal", rdata, 16'hBEEF);

      wait_idle();
      mon_on = 0;
      stuck = 1;
      we = 1; addr = 16'h0055; wdata = 16'h1234; req = 1;
      @(negedge clk);
      req = 0;
      for (int k = 0; k < 20 && !en; k++) @(negedge clk);
      chk("reached_strobe", en, 1);
      #3 rst_n = 0;
      #1;
      chk("midrst_en", en, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_mar", mar, 0);
      chk("midrst_done", done, 0);
      chk("midrst_rdata", rdata, 0);
      @(negedge clk);
      rst_n = 1; stuck = 0;
      q.delete(); model_mdr = 0; exp_rdata = 0; exp_err = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("postrst_no_done", done, 0);
      end
      mon_on = 1;

      for (int i = 0; i < 40; i++)
         do_xfer(1'($urandom), 16'($urandom_range(0, 31)), 16'($urandom),
                 ($urandom_range(0, 7) == 0), 1);
      wait_idle();
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
